// File: rtl/pulse_queue_pkg.sv
// Shared constants for the pulse queue selector: arbitration mode encodings
// and the width of the optional drop counter.
package pulse_queue_pkg;
  localparam logic MODE_FIXED       = 1'b0;
  localparam logic MODE_RR          = 1'b1;
  localparam int   DROP_COUNT_WIDTH = 16;
endpackage

// File: rtl/pulse_priority_pick.sv
// Combinational priority encoder. In fixed mode the highest set request wins.
// In round-robin mode the first set request at or above start wins, wrapping past CHANNELS-1.
module pulse_priority_pick
  import pulse_queue_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic [CHANNELS-1:0]    req,
  input  logic [INDEX_WIDTH-1:0] start,
  input  logic                   mode,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] sel
);

  int c;

  always_comb begin
    found = |req;
    sel   = '0;
    c     = 0;
    if (mode == MODE_RR) begin
      // Scan from the farthest offset to the nearest so the nearest hit is the last write.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        c = int'(start) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (req[c]) sel = INDEX_WIDTH'(c);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (req[i]) sel = INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/pulse_queue_selector.sv
// Captures per-channel pulses into pending bits and emits one event per cycle
// over a valid/ready handshake. Define PULSE_QUEUE_DROP_COUNT_EN to add drop_count.
module pulse_queue_selector
  import pulse_queue_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    pulses,
  input  logic [CHANNELS-1:0]    mask,
  input  logic                   rr_mode,
  input  logic                   ready,
  output logic                   trigger,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [CHANNELS-1:0]    overflow,
  input  logic                   overflow_clear
`ifdef PULSE_QUEUE_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
`endif
);

  if (CHANNELS < 2 || CHANNELS > 256 || CHANNELS > (1 << INDEX_WIDTH)) begin : g_bad_cfg
    $error("pulse_queue_selector: CHANNELS must be 2..256 and fit in INDEX_WIDTH bits");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST_CH = INDEX_WIDTH'(CHANNELS - 1);

  logic [CHANNELS-1:0]    pending, act, held, elig, load_oh, ovf_new;
  logic [INDEX_WIDTH-1:0] last_grant, start, sel;
  logic                   found, free, load;

  assign free    = !trigger || ready;
  assign held    = (trigger && !ready) ? (CHANNELS'(1) << index) : '0;
  assign act     = (pending | pulses) & mask;
  assign elig    = act & ~held;
  assign start   = (last_grant == LAST_CH) ? '0 : last_grant + 1'b1;
  assign load    = free && found;
  assign load_oh = load ? (CHANNELS'(1) << sel) : '0;
  // A stalled output channel re-pends on its first new pulse; only a second one is lost.
  assign ovf_new = pending & pulses & mask & ~load_oh;

  pulse_priority_pick #(
    .CHANNELS   (CHANNELS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_pick (
    .req  (elig),
    .start(start),
    .mode (rr_mode),
    .found(found),
    .sel  (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      trigger    <= 1'b0;
      index      <= '0;
      overflow   <= '0;
      last_grant <= LAST_CH;
    end else begin
      pending  <= act & ~load_oh;
      overflow <= (overflow & {CHANNELS{!overflow_clear}}) | ovf_new;
      if (free) begin
        trigger <= found;
        if (found) begin
          index      <= sel;
          last_grant <= sel;
        end
      end
    end
  end

`ifdef PULSE_QUEUE_DROP_COUNT_EN
  int                          ovf_n;
  logic [DROP_COUNT_WIDTH-1:0] drop_base;
  logic [DROP_COUNT_WIDTH:0]   drop_sum;

  always_comb begin
    ovf_n = 0;
    for (int i = 0; i < CHANNELS; i++) ovf_n = ovf_n + int'(ovf_new[i]);
    drop_base = overflow_clear ? '0 : drop_count;
    drop_sum  = {1'b0, drop_base} + (DROP_COUNT_WIDTH + 1)'(ovf_n);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else     drop_count <= drop_sum[DROP_COUNT_WIDTH] ? '1 : drop_sum[DROP_COUNT_WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_pulse_queue_selector.sv
// Directed and randomized checks of pulse_queue_selector against an array-based
// reference model; honours PULSE_QUEUE_DROP_COUNT_EN.
module tb_pulse_queue_selector;
  localparam int CH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] pulses, mask;
  logic          rr_mode, ready, overflow_clear;
  logic          trigger;
  logic [7:0]    index;
  logic [CH-1:0] overflow;
`ifdef PULSE_QUEUE_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // reference model state
  bit [CH-1:0] m_pend, m_ovf;
  bit          m_trig;
  logic [7:0]  m_idx;
  int          m_last;
  int          m_drop;

  pulse_queue_selector #(.CHANNELS(CH), .INDEX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pulses(pulses), .mask(mask), .rr_mode(rr_mode),
    .ready(ready), .trigger(trigger), .index(index), .overflow(overflow),
    .overflow_clear(overflow_clear)
`ifdef PULSE_QUEUE_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : model
    bit          stalled;
    int          load, nov;
    bit [CH-1:0] act, novf, npend;
    if (rst) begin
      m_pend <= '0; m_ovf <= '0; m_trig <= 1'b0; m_idx <= '0; m_last <= CH - 1; m_drop <= 0;
    end else begin
      stalled = m_trig && !ready;
      load = -1;
      for (int c = 0; c < CH; c++) act[c] = (m_pend[c] | pulses[c]) & mask[c];
      if (!stalled) begin
        if (rr_mode) begin
          for (int k = 1; k <= CH; k++)
            if (load < 0 && act[(m_last + k) % CH]) load = (m_last + k) % CH;
        end else begin
          for (int c = CH - 1; c >= 0; c--)
            if (load < 0 && act[c]) load = c;
        end
      end
      nov = 0;
      for (int c = 0; c < CH; c++) begin
        novf[c]  = m_pend[c] & pulses[c] & mask[c] & (c != load);
        npend[c] = act[c] & (c != load);
        nov      = nov + int'(novf[c]);
      end
      m_pend <= npend;
      m_ovf  <= (overflow_clear ? '0 : m_ovf) | novf;
      m_drop <= ((overflow_clear ? 0 : m_drop) + nov > 65535) ? 65535 : (overflow_clear ? 0 : m_drop) + nov;
      if (!stalled) begin
        m_trig <= (load >= 0);
        if (load >= 0) begin
          m_idx  <= 8'(load);
          m_last <= load;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (trigger !== m_trig) begin bad++; $display("FAIL cyc_trigger: dut=%0d model=%0d t=%0t", trigger, m_trig, $time); end
      total++;
      if (index !== m_idx) begin bad++; $display("FAIL cyc_index: dut=%0d model=%0d t=%0t", index, m_idx, $time); end
      total++;
      if (overflow !== m_ovf) begin bad++; $display("FAIL cyc_overflow: dut=%h model=%h t=%0t", overflow, m_ovf, $time); end
`ifdef PULSE_QUEUE_DROP_COUNT_EN
      total++;
      if (int'(drop_count) != m_drop) begin bad++; $display("FAIL cyc_drop: dut=%0d model=%0d t=%0t", drop_count, m_drop, $time); end
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // literal expectation checked against both the DUT and the model
  task automatic expect_lit(input string name, input bit t, input int i);
    total++;
    if (trigger !== t || (t && int'(index) != i)) begin
      bad++; $display("FAIL %s: dut trig=%0d idx=%0d want trig=%0d idx=%0d", name, trigger, index, t, i);
    end
    total++;
    if (m_trig !== t || (t && int'(m_idx) != i)) begin
      bad++; $display("FAIL %s_model: trig=%0d idx=%0d want trig=%0d idx=%0d", name, m_trig, m_idx, t, i);
    end
  endtask

  task automatic expect_ovf(input string name, input logic [CH-1:0] want);
    total++;
    if (overflow !== want) begin bad++; $display("FAIL %s: overflow=%h want=%h", name, overflow, want); end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    bit [3:0] pv;
    int       want;
    rst = 1'b1; pulses = '0; mask = '1; rr_mode = 1'b0; ready = 1'b1; overflow_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    expect_lit("reset", 1'b0, 0);
    total++; if (index !== 8'd0) begin bad++; $display("FAIL reset_index: got=%0d want=0", index); end
    expect_ovf("reset_ovf", '0);

    // legacy 4-channel behaviour on the low channels
    mask = 16'h000F;
    for (int p = 1; p < 16; p++) begin
      pv = 4'(p); want = 0;
      for (int b = 0; b < 4; b++) if (pv[b]) want = b;
      pulses = 16'(p); tick(); pulses = '0;
      expect_lit("legacy_msb", 1'b1, want);
      repeat (4) tick();
      expect_lit("legacy_idle", 1'b0, 0);
    end
    pulses = 16'b1011; tick(); pulses = '0;
    expect_lit("seq1011_a", 1'b1, 3); tick();
    expect_lit("seq1011_b", 1'b1, 1); tick();
    expect_lit("seq1011_c", 1'b1, 0); tick();
    expect_lit("seq1011_d", 1'b0, 0);

    // round robin from reset
    mask = '1; do_reset(); rr_mode = 1'b1;
    pulses = 16'h8421; tick(); pulses = '0;
    expect_lit("rr_0", 1'b1, 0);  tick();
    expect_lit("rr_5", 1'b1, 5);  tick();
    expect_lit("rr_10", 1'b1, 10); tick();
    expect_lit("rr_15", 1'b1, 15); tick();
    expect_lit("rr_idle", 1'b0, 0);

    // stall
    rr_mode = 1'b0; ready = 1'b0;
    pulses = 16'h0008; tick();
    expect_lit("stall_first", 1'b1, 3);
    pulses = 16'h0080; tick(); pulses = '0;
    for (int i = 0; i < 5; i++) begin tick(); expect_lit("stall_hold", 1'b1, 3); end
    ready = 1'b1; tick();
    expect_lit("stall_next", 1'b1, 7); tick();
    expect_lit("stall_idle", 1'b0, 0);

    // overflow, including a pulse on the held channel
    ready = 1'b0;
    pulses = 16'h0004; tick(); expect_lit("ovf_hold2", 1'b1, 2);
    pulses = 16'h0004; tick();
    pulses = 16'h0200; tick();
    pulses = 16'h0000; tick();
    pulses = 16'h0200; tick(); pulses = '0;
    expect_ovf("ovf_ch9", 16'h0200);
    ready = 1'b1; tick(); expect_lit("ovf_deliver9", 1'b1, 9);
    tick(); expect_lit("ovf_deliver2", 1'b1, 2);
    tick(); expect_lit("ovf_idle", 1'b0, 0);
    overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    expect_ovf("ovf_cleared", '0);
    ready = 1'b0;
    pulses = 16'h0004; tick();
    pulses = 16'h0200; tick();
    pulses = 16'h0200; overflow_clear = 1'b1; tick();
    pulses = '0; overflow_clear = 1'b0;
    expect_ovf("ovf_clear_vs_new", 16'h0200);
    ready = 1'b1; repeat (3) tick();

    // mask drops a pending channel but not the held one
    ready = 1'b0;
    pulses = 16'h0002; tick();
    pulses = 16'h0020; tick(); pulses = '0;
    mask = ~16'h0022; tick();
    expect_lit("mask_held", 1'b1, 1);
    mask = '1; ready = 1'b1; tick();
    expect_lit("mask_dropped", 1'b0, 0);

    // reset during stall restarts round robin at 0
    rr_mode = 1'b1;
    pulses = 16'h0040; tick(); expect_lit("rst_pre6", 1'b1, 6);
    ready = 1'b0; pulses = 16'h0200; tick(); tick(); pulses = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    expect_lit("rst_stall", 1'b0, 0);
    total++; if (index !== 8'd0) begin bad++; $display("FAIL rst_stall_index: got=%0d want=0", index); end
    expect_ovf("rst_stall_ovf", '0);
    ready = 1'b1; pulses = 16'h0101; tick(); pulses = '0;
    expect_lit("rst_rr0", 1'b1, 0); tick();
    expect_lit("rst_rr8", 1'b1, 8); tick();
    expect_lit("rst_rr_idle", 1'b0, 0);

`ifdef PULSE_QUEUE_DROP_COUNT_EN
    rr_mode = 1'b0; overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    ready = 1'b0;
    pulses = 16'h0004; tick();
    pulses = 16'h0052; tick();
    pulses = 16'h0052; tick(); pulses = '0;
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL drop_plus3: got=%0d want=3", drop_count); end
    pulses = '1;
    repeat (4300) tick();
    pulses = '0;
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL drop_sat: got=%h want=ffff", drop_count); end
    ready = 1'b1; do_reset();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      pulses         = 16'($urandom) & 16'($urandom) & 16'($urandom);
      mask           = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF;
      ready          = ($urandom_range(0, 2) != 0);
      overflow_clear = ($urandom_range(0, 19) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      tick();
    end
    rst = 1'b0; pulses = '0; mask = '1; ready = 1'b1; overflow_clear = 1'b0;
    repeat (20) tick();
    expect_lit("final_idle", 1'b0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
